// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcode constants and decode helpers shared with the control state machine
package proc_pkg;

  typedef enum logic [3:0] {
    NOP    = 4'd0,
    ADD    = 4'd1,
    SUB    = 4'd2,
    XOR_OP = 4'd3,
    MUL    = 4'd4,
    DIV    = 4'd5,
    JUMPZ  = 4'd6,
    JUMP   = 4'd7,
    SUBI   = 4'd8,
    ADDI   = 4'd9,
    WRITE  = 4'd10,
    READ   = 4'd11,
    LDMAR  = 4'd12,
    MARMEM = 4'd13,
    MOV    = 4'd14,
    CLAC   = 4'd15
  } opcode_t;

  localparam logic [7:0] STOP_CODE = 8'hFF;

  // Opcodes that write a result back to the destination register r0.
  function automatic logic is_wb(input logic [3:0] op);
    case (op)
      ADD, SUB, XOR_OP, MUL, DIV, SUBI, ADDI, READ, MARMEM, MOV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_r1(input logic [3:0] op);
    case (op)
      ADD, SUB, XOR_OP, MUL, DIV, SUBI, ADDI, MOV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_r2(input logic [3:0] op);
    case (op)
      ADD, SUB, XOR_OP, MUL, DIV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - read-after-write compare of decode sources against stage 2/3 destinations
module hazard_detect
  import proc_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] r1,
  input  logic [3:0] r2,
  input  logic [3:0] op2,
  input  logic [3:0] dst2,
  input  logic [3:0] op3,
  input  logic [3:0] dst3,
  output logic       hazard
);

  logic use1, use2, hit2, hit3;

  always_comb begin
    use1   = uses_r1(op);
    use2   = uses_r2(op);
    hit2   = is_wb(op2) && ((use1 && (r1 == dst2)) || (use2 && (r2 == dst2)));
    hit3   = is_wb(op3) && ((use1 && (r1 == dst3)) || (use2 && (r2 == dst3)));
    hazard = hit2 || hit3;
  end

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - program counter plus decode, stage-2 and stage-3 opcode/destination registers
module decode_pipe
  import proc_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            pc_incr,
  input  logic            PC_rst,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_val,
  input  logic            flush,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  input  logic            write_dec_reg,
  input  logic            long_inst_write,
  input  logic            write_dec_reg2,
  input  logic            write_dec_reg3,
  output logic [3:0]      op_out,
  output logic [3:0]      dec_r0_out,
  output logic [3:0]      dec_r1_out,
  output logic [3:0]      dec_r2_out,
  output logic [15:0]     imm_out,
  output logic [3:0]      op_out2,
  output logic [3:0]      dec_r0_out2,
  output logic [3:0]      op_out3,
  output logic [3:0]      dec_r0_out3,
  output logic            hazard,
  output logic            stop_seen,
  output logic [15:0]     retired
);

  logic [PC_W-1:0] pc;

  assign instr_addr = pc;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (PC_rst) begin
      pc <= '0;
    end else if (pc_load) begin
      pc <= pc_load_val;
    end else if (pc_incr && !stop_seen) begin
      pc <= pc + PC_W'(1);
    end
  end

  // All stage registers read pre-edge values, so simultaneous strobes shift
  // exactly one stage; stage 3 ignores flush so the jump itself completes.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      op_out      <= '0;
      dec_r0_out  <= '0;
      dec_r1_out  <= '0;
      dec_r2_out  <= '0;
      op_out2     <= '0;
      dec_r0_out2 <= '0;
      op_out3     <= '0;
      dec_r0_out3 <= '0;
      stop_seen   <= 1'b0;
      retired     <= '0;
    end else begin
      if (flush) begin
        op_out     <= '0;
        dec_r0_out <= '0;
        dec_r1_out <= '0;
        dec_r2_out <= '0;
      end else if (write_dec_reg) begin
        op_out     <= instr_data[15:12];
        dec_r0_out <= instr_data[11:8];
        dec_r1_out <= instr_data[7:4];
        dec_r2_out <= instr_data[3:0];
        if (instr_data[15:8] == STOP_CODE) begin
          stop_seen <= 1'b1;
        end
      end

      if (flush) begin
        op_out2     <= '0;
        dec_r0_out2 <= '0;
      end else if (write_dec_reg2) begin
        op_out2     <= op_out;
        dec_r0_out2 <= dec_r0_out;
      end

      if (write_dec_reg3) begin
        op_out3     <= op_out2;
        dec_r0_out3 <= dec_r0_out2;
        if (op_out2 != NOP) begin
          retired <= retired + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      imm_out <= '0;
    end else if (long_inst_write) begin
      imm_out <= instr_data;
    end
  end

  hazard_detect u_hazard_detect (
    .op     (op_out),
    .r1     (dec_r1_out),
    .r2     (dec_r2_out),
    .op2    (op_out2),
    .dst2   (dec_r0_out2),
    .op3    (op_out3),
    .dst3   (dec_r0_out3),
    .hazard (hazard)
  );

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - directed and randomized checks of decode_pipe against a behavioural model
module tb_decode_pipe;

  localparam int PC_W = 8;

  logic            clk_in = 1'b0;
  logic            rst_n;
  logic            pc_incr, PC_rst, pc_load, flush;
  logic [PC_W-1:0] pc_load_val;
  logic [PC_W-1:0] instr_addr;
  logic [15:0]     instr_data;
  logic            write_dec_reg, long_inst_write, write_dec_reg2, write_dec_reg3;
  logic [3:0]      op_out, dec_r0_out, dec_r1_out, dec_r2_out;
  logic [15:0]     imm_out;
  logic [3:0]      op_out2, dec_r0_out2, op_out3, dec_r0_out3;
  logic            hazard, stop_seen;
  logic [15:0]     retired;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PC_W-1:0] m_pc;
  logic [15:0]     m_dec, m_imm, m_ret;
  logic [7:0]      m_s2, m_s3;
  logic            m_stop;

  always #5 clk_in = ~clk_in;

  decode_pipe #(.PC_W(PC_W)) dut (
    .clk_in          (clk_in),
    .rst_n           (rst_n),
    .pc_incr         (pc_incr),
    .PC_rst          (PC_rst),
    .pc_load         (pc_load),
    .pc_load_val     (pc_load_val),
    .flush           (flush),
    .instr_addr      (instr_addr),
    .instr_data      (instr_data),
    .write_dec_reg   (write_dec_reg),
    .long_inst_write (long_inst_write),
    .write_dec_reg2  (write_dec_reg2),
    .write_dec_reg3  (write_dec_reg3),
    .op_out          (op_out),
    .dec_r0_out      (dec_r0_out),
    .dec_r1_out      (dec_r1_out),
    .dec_r2_out      (dec_r2_out),
    .imm_out         (imm_out),
    .op_out2         (op_out2),
    .dec_r0_out2     (dec_r0_out2),
    .op_out3         (op_out3),
    .dec_r0_out3     (dec_r0_out3),
    .hazard          (hazard),
    .stop_seen       (stop_seen),
    .retired         (retired)
  );

  function automatic logic model_hazard(input logic [15:0] word, input logic [7:0] s2,
                                        input logic [7:0] s3);
    int wb_ops[10] = '{1, 2, 3, 4, 5, 8, 9, 11, 13, 14};
    int srcs[$];
    int op;
    logic wb2, wb3, h;
    op = int'(word[15:12]);
    if (op >= 1 && op <= 5) begin
      srcs.push_back(int'(word[7:4]));
      srcs.push_back(int'(word[3:0]));
    end else if (op == 8 || op == 9 || op == 14) begin
      srcs.push_back(int'(word[7:4]));
    end
    wb2 = 1'b0;
    wb3 = 1'b0;
    foreach (wb_ops[i]) begin
      if (wb_ops[i] == int'(s2[7:4])) wb2 = 1'b1;
      if (wb_ops[i] == int'(s3[7:4])) wb3 = 1'b1;
    end
    h = 1'b0;
    foreach (srcs[i]) begin
      if (wb2 && srcs[i] == int'(s2[3:0])) h = 1'b1;
      if (wb3 && srcs[i] == int'(s3[3:0])) h = 1'b1;
    end
    return h;
  endfunction

  task automatic clear_inputs();
    pc_incr = 0; PC_rst = 0; pc_load = 0; pc_load_val = '0; flush = 0;
    write_dec_reg = 0; long_inst_write = 0; write_dec_reg2 = 0; write_dec_reg3 = 0;
  endtask

  task automatic model_step();
    logic [15:0] n_dec;
    logic [7:0]  n_s2, n_s3;
    if (PC_rst) m_pc = '0;
    else if (pc_load) m_pc = pc_load_val;
    else if (pc_incr && !m_stop) m_pc = m_pc + 1'b1;
    n_s3 = write_dec_reg3 ? m_s2 : m_s3;
    if (write_dec_reg3 && m_s2[7:4] != 0) m_ret = m_ret + 1'b1;
    n_s2 = flush ? 8'h00 : (write_dec_reg2 ? m_dec[15:8] : m_s2);
    n_dec = flush ? 16'h0 : (write_dec_reg ? instr_data : m_dec);
    if (!flush && write_dec_reg && instr_data[15:8] == 8'hFF) m_stop = 1'b1;
    if (long_inst_write) m_imm = instr_data;
    m_dec = n_dec;
    m_s2  = n_s2;
    m_s3  = n_s3;
  endtask

  // Advance one clock, update the model, sample just after the edge, then drop strobes.
  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 0;
    clear_inputs();
    instr_data = '0;
    m_pc = '0; m_dec = '0; m_imm = '0; m_ret = '0; m_s2 = '0; m_s3 = '0; m_stop = 0;
    @(negedge clk_in);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({instr_addr, op_out, dec_r0_out, dec_r1_out, dec_r2_out} !== '0) begin
      errors++;
      $display("FAIL reset_pc_dec: got %h/%h%h%h%h required 0", instr_addr, op_out, dec_r0_out,
               dec_r1_out, dec_r2_out);
    end
    checks++;
    if ({op_out2, dec_r0_out2, op_out3, dec_r0_out3, imm_out, retired, stop_seen, hazard} !== '0) begin
      errors++;
      $display("FAIL reset_stages: got s2=%h%h s3=%h%h imm=%h ret=%h stop=%b haz=%b required 0",
               op_out2, dec_r0_out2, op_out3, dec_r0_out3, imm_out, retired, stop_seen, hazard);
    end
  endtask

  task automatic test_pc();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pc_incr = 1;
      tick();
    end
    checks++;
    if (instr_addr !== 8'd3) begin
      errors++; $display("FAIL pc_incr3: got %h required 03", instr_addr);
    end
    pc_load = 1; pc_load_val = 8'h40; pc_incr = 1;
    tick();
    checks++;
    if (instr_addr !== 8'h40) begin
      errors++; $display("FAIL pc_load_priority: got %h required 40", instr_addr);
    end
    PC_rst = 1; pc_load = 1; pc_load_val = 8'h77; pc_incr = 1;
    tick();
    checks++;
    if (instr_addr !== 8'h00) begin
      errors++; $display("FAIL pc_rst: got %h required 00", instr_addr);
    end
    pc_load = 1; pc_load_val = 8'hFF;
    tick();
    pc_incr = 1;
    tick();
    checks++;
    if (instr_addr !== 8'h00) begin
      errors++; $display("FAIL pc_wrap: got %h required 00", instr_addr);
    end
  endtask

  task automatic test_shift();
    do_reset();
    instr_data = 16'h1123; write_dec_reg = 1; long_inst_write = 1;
    tick();
    checks++;
    if ({op_out, dec_r1_out, dec_r2_out, imm_out} !== {4'd1, 4'd2, 4'd3, 16'h1123}) begin
      errors++;
      $display("FAIL shift_decode: got op=%h r1=%h r2=%h imm=%h required 1 2 3 1123", op_out,
               dec_r1_out, dec_r2_out, imm_out);
    end
    write_dec_reg2 = 1;
    tick();
    checks++;
    if ({op_out2, dec_r0_out2} !== 8'h11) begin
      errors++; $display("FAIL shift_stage2: got %h%h required 11", op_out2, dec_r0_out2);
    end
    write_dec_reg3 = 1;
    tick();
    checks++;
    if ({op_out3, dec_r0_out3, retired} !== {8'h11, 16'd1}) begin
      errors++;
      $display("FAIL shift_stage3: got %h%h ret=%0d required 11 ret=1", op_out3, dec_r0_out3,
               retired);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    instr_data = 16'h1100; write_dec_reg = 1;
    tick();
    instr_data = 16'h2213; write_dec_reg = 1; write_dec_reg2 = 1;
    tick();
    checks++;
    if (hazard !== 1'b1) begin
      errors++; $display("FAIL hazard_stage2_raw: got %b required 1", hazard);
    end
    instr_data = 16'h6100; write_dec_reg = 1;
    tick();
    instr_data = 16'h2213; write_dec_reg = 1; write_dec_reg2 = 1;
    tick();
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("FAIL hazard_jumpz_clear: got %b required 0", hazard);
    end
  endtask

  task automatic test_flush();
    do_reset();
    instr_data = 16'h1200; write_dec_reg = 1;
    tick();
    instr_data = 16'h9345; write_dec_reg = 1; write_dec_reg2 = 1;
    tick();
    write_dec_reg2 = 1; write_dec_reg3 = 1;
    tick();
    instr_data = 16'h5555; write_dec_reg = 1; flush = 1; write_dec_reg2 = 1;
    tick();
    checks++;
    if ({op_out, dec_r0_out, dec_r1_out, dec_r2_out, op_out2, dec_r0_out2} !== 24'h0) begin
      errors++;
      $display("FAIL flush_clear: got dec=%h%h%h%h s2=%h%h required 0", op_out, dec_r0_out,
               dec_r1_out, dec_r2_out, op_out2, dec_r0_out2);
    end
    checks++;
    if ({op_out3, dec_r0_out3, retired} !== {8'h12, 16'd1}) begin
      errors++;
      $display("FAIL flush_stage3_hold: got %h%h ret=%0d required 12 ret=1", op_out3,
               dec_r0_out3, retired);
    end
    write_dec_reg3 = 1;
    tick();
    checks++;
    if ({op_out3, dec_r0_out3, retired} !== {8'h00, 16'd1}) begin
      errors++;
      $display("FAIL flush_nop_retire: got %h%h ret=%0d required 00 ret=1", op_out3,
               dec_r0_out3, retired);
    end
  endtask

  task automatic test_stop();
    do_reset();
    pc_load = 1; pc_load_val = 8'h10;
    tick();
    instr_data = 16'hFF00; write_dec_reg = 1;
    tick();
    checks++;
    if (stop_seen !== 1'b1) begin
      errors++; $display("FAIL stop_set: got %b required 1", stop_seen);
    end
    pc_incr = 1;
    tick();
    checks++;
    if (instr_addr !== 8'h10) begin
      errors++; $display("FAIL stop_freeze_pc: got %h required 10", instr_addr);
    end
    pc_load = 1; pc_load_val = 8'h22; pc_incr = 1;
    tick();
    checks++;
    if (instr_addr !== 8'h22 || stop_seen !== 1'b1) begin
      errors++;
      $display("FAIL stop_load_honoured: got pc=%h stop=%b required 22 1", instr_addr, stop_seen);
    end
    @(negedge clk_in);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({instr_addr, op_out, dec_r0_out, dec_r1_out, dec_r2_out, imm_out, op_out2, dec_r0_out2,
         op_out3, dec_r0_out3, hazard, stop_seen, retired} !== '0) begin
      errors++;
      $display("FAIL async_reset: got pc=%h dec=%h%h%h%h stop=%b ret=%h required 0", instr_addr,
               op_out, dec_r0_out, dec_r1_out, dec_r2_out, stop_seen, retired);
    end
    m_pc = '0; m_dec = '0; m_imm = '0; m_ret = '0; m_s2 = '0; m_s3 = '0; m_stop = 0;
    @(negedge clk_in);
    rst_n = 1;
    pc_incr = 1;
    tick();
    checks++;
    if (instr_addr !== 8'h01) begin
      errors++; $display("FAIL release_from_reset: got %h required 01", instr_addr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pc_incr         = 1'($urandom_range(0, 1));
      PC_rst          = ($urandom_range(0, 15) == 0);
      pc_load         = ($urandom_range(0, 7) == 0);
      pc_load_val     = 8'($urandom_range(0, 255));
      flush           = ($urandom_range(0, 7) == 0);
      write_dec_reg   = 1'($urandom_range(0, 1));
      long_inst_write = 1'($urandom_range(0, 1));
      write_dec_reg2  = 1'($urandom_range(0, 1));
      write_dec_reg3  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0)
        instr_data = {8'hFF, 8'($urandom_range(0, 255))};
      else
        instr_data = {4'($urandom_range(0, 15)), 2'b00, 2'($urandom_range(0, 3)),
                      2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))};
      tick();
      checks++;
      if (instr_addr !== m_pc) begin
        errors++; $display("FAIL rand_pc[%0d]: got %h required %h", n, instr_addr, m_pc);
      end
      checks++;
      if ({op_out, dec_r0_out, dec_r1_out, dec_r2_out} !== m_dec) begin
        errors++;
        $display("FAIL rand_decode[%0d]: got %h%h%h%h required %h", n, op_out, dec_r0_out,
                 dec_r1_out, dec_r2_out, m_dec);
      end
      checks++;
      if ({op_out2, dec_r0_out2, op_out3, dec_r0_out3} !== {m_s2, m_s3}) begin
        errors++;
        $display("FAIL rand_stages[%0d]: got %h%h %h%h required %h %h", n, op_out2, dec_r0_out2,
                 op_out3, dec_r0_out3, m_s2, m_s3);
      end
      checks++;
      if ({imm_out, retired, stop_seen} !== {m_imm, m_ret, m_stop}) begin
        errors++;
        $display("FAIL rand_imm_ret_stop[%0d]: got %h %h %b required %h %h %b", n, imm_out,
                 retired, stop_seen, m_imm, m_ret, m_stop);
      end
      checks++;
      if (hazard !== model_hazard(m_dec, m_s2, m_s3)) begin
        errors++;
        $display("FAIL rand_hazard[%0d]: got %b required %b", n, hazard,
                 model_hazard(m_dec, m_s2, m_s3));
      end
    end
  endtask

  initial begin
    rst_n = 0;
    instr_data = '0;
    clear_inputs();
    test_reset();
    test_pc();
    test_shift();
    test_hazard();
    test_flush();
    test_stop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Instruction-fetch and decode pipeline registers for the pipelined processor. The block holds the program counter and addresses instruction memory. It splits each 16-bit instruction word into opcode and register fields and carries opcode/destination through the IR-read, ALU and write-back stage registers. Its outputs (`op_out`, `dec_r*_out`, `op_out2`, `op_out3`, `dec_r0_out3`) feed the control state machine, and its strobe inputs are driven by that state machine.

## Interface
- `PC_W`, 8, program-counter and instruction-address width
- `clk_in`  in  1  processor clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pc_incr`  in  1  advance PC by one
- `PC_rst`  in  1  synchronous PC clear
- `pc_load`  in  1  load PC with `pc_load_val` (taken jump)
- `pc_load_val`  in  PC_W  jump target
- `flush`  in  1  squash decode and stage-2 registers (taken jump)
- `instr_addr`  out  PC_W  instruction-memory address (= PC)
- `instr_data`  in  16  instruction word, combinational read of `instr_addr`
- `write_dec_reg`  in  1  capture `instr_data` into decode register
- `long_inst_write`  in  1  capture `instr_data` into immediate register
- `write_dec_reg2`  in  1  advance decode register into stage 2
- `write_dec_reg3`  in  1  advance stage 2 into stage 3
- `op_out`, `dec_r0_out`, `dec_r1_out`, `dec_r2_out`  out  4 each  decode fields: bits [15:12], [11:8], [7:4], [3:0]
- `imm_out`  out  16  immediate word for SUBI/ADDI
- `op_out2`, `dec_r0_out2`  out  4 each  stage-2 opcode/destination
- `op_out3`, `dec_r0_out3`  out  4 each  stage-3 opcode/destination
- `hazard`  out  1  read-after-write hazard on decode-register sources
- `stop_seen`  out  1  sticky: STOP (`{op,r0}`=8'hFF) captured
- `retired`  out  16  count of non-NOP opcodes entering stage 3

## Operation
- PC priority: `PC_rst` (PC←0) > `pc_load` (PC←`pc_load_val`) > `pc_incr` (PC←PC+1, wraps 2^PC_W−1→0). `pc_incr` is ignored while `stop_seen`=1. `PC_rst` and `pc_load` are honoured regardless.
- Decode register: `flush` forces all four fields to 0 (NOP). Otherwise `write_dec_reg` loads `instr_data`.
- Stage 2: `flush` forces `op_out2`/`dec_r0_out2` to 0. Otherwise `write_dec_reg2` loads `op_out`/`dec_r0_out`.
- Stage 3: `write_dec_reg3` loads stage-2 values and is not affected by `flush`, so the in-flight jump completes.
- Simultaneous strobes shift using pre-edge values: a true pipeline with no fall-through.
- `imm_out` loads `instr_data` on `long_inst_write`, independent of the other strobes.
- `stop_seen` sets on the edge at which the decode register loads a word with [15:8]=8'hFF. It is cleared only by `rst_n`.
- `retired` increments when `write_dec_reg3`=1 and the incoming stage-2 opcode ≠ 0. It wraps at 16'hFFFF→0.
- Write-back opcodes (WB): ADD 1, SUB 2, XOR 3, MUL 4, DIV 5, SUBI 8, ADDI 9, READ 11, MARMEM 13, MOV 14.
- Decode sources:
  - ops 1–5 use r1 and r2.
  - ops 8, 9, 14 use r1.
  - All other ops use none.
- `hazard` = (any source = `dec_r0_out2` and `op_out2`∈WB) or (any source = `dec_r0_out3` and `op_out3`∈WB). It is combinational from the registers.

## Timing
- Reset (async assert, sync-free release): PC, all fields, `imm_out`, `retired` = 0; `stop_seen`=0. Consequently `instr_addr`=0 and `hazard`=0.
- `instr_addr` changes one edge after the PC command. `instr_data` must be valid before the next edge on which `write_dec_reg` is sampled.
- Field outputs are registered and valid the cycle after their strobe. There is zero-cycle combinational latency from the registers to `hazard`.
- `rst_n` asserted mid-stream clears all state immediately. The first edge after release behaves as from reset.
- `flush` with `write_dec_reg` on the same edge: flush wins, and the fetched word is dropped.

## Structure
- Shared package `proc_pkg`:
  - opcode constants NOP..CLAC (0..15) and STOP (8'hFF);
  - WB-membership and source-use functions, reused by the control state machine.
- One sub-module, `hazard_detect`: purely combinational source/destination compare producing `hazard`.

## Test plan
- Reset then `pc_incr` ×3 → `instr_addr`=3. Next, `pc_load`=1 with `pc_load_val`=8'h40 and `pc_incr`=1 on the same edge → `instr_addr`=8'h40. Then `PC_rst` → 0.
- PC=8'hFF, `pc_incr` → `instr_addr`=0 (wrap).
- Shift 16'h1123 through three stages:
  - `op_out`=1, `dec_r1_out`=2, `dec_r2_out`=3;
  - then `op_out2`=1, `dec_r0_out2`=1;
  - then `op_out3`=1, `dec_r0_out3`=1 and `retired`=1.
- Hazard:
  - Stage 2 holds ADD r1; decode holds 16'h2213 (SUB r2,r1,r3) → `hazard`=1.
  - Replace stage 2 with JUMPZ (op 6) → `hazard`=0.
- `flush` with stage 2 = 16'h9xxx and stage 3 = ADD r2 → decode and stage 2 become 0; stage 3 holds op 1/dest 2; a following `write_dec_reg3` loads NOP and `retired` is unchanged.
- Load 16'hFF00 → `stop_seen`=1 and subsequent `pc_incr` leaves PC unchanged. Assert `rst_n`=0 mid-run → all outputs 0 asynchronously.
